// File: rtl/dbg_pkg.sv
// Shared definitions for the register-dump UART debug transmitter.
// Contents:
//   tx_state_e  - bit-level state of the byte serializer (IDLE/START/DATA/STOP)
//   DUMP_BYTES  - number of data bytes in one dump (32 registers x 4 bytes)
//   NUM_REGS    - number of registers in the flat dump
//   DUMP_W      - width of the flat dump bus
package dbg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int DUMP_BYTES = 128;
    localparam int NUM_REGS   = 32;
    localparam int DUMP_W     = NUM_REGS * 32;

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit,
// each bit held CLKS_PER_BIT cycles.
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-low reset
//   valid - a byte is offered on data
//   data  - byte to send
//   tx    - serial line, registered, idles high
//   ready - byte on data is taken at this edge when valid is also high
//
// Handshake: a byte moves when valid && ready are both high at a rising
// edge. ready is high in IDLE and in the final cycle of a stop bit, so a
// byte offered during the last stop cycle follows with no idle gap.
// ready depends only on local flops, never on valid.
module uart_tx_byte
    import dbg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    data_q;
    logic          tx_q;

    logic          bit_end;
    logic [2:0]    bit_nxt;

    assign bit_end = (cnt_q == CNT_LAST);
    assign bit_nxt = bit_q + 3'd1;
    assign ready   = (state_q == IDLE) || ((state_q == STOP) && bit_end);
    assign tx      = tx_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            // Bit-cycle counter runs in every non-idle state and wraps at
            // the end of each bit period.
            cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    tx_q  <= 1'b1;
                    if (valid) begin
                        state_q <= START;
                        data_q  <= data;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q <= DATA;
                        bit_q   <= 3'd0;
                        tx_q    <= data_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_nxt;
                            tx_q  <= data_q[bit_nxt];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (valid) begin
                            state_q <= START;
                            data_q  <= data;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/reg_dump_uart_tx.sv
// Register-file dump transmitter. A start request snapshots the flat
// 32x32-bit register dump, then one header byte and 128 data bytes
// (x0..x31, each little-endian) are sent back-to-back over UART 8N1.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-low reset
//   start    - dump request, only honoured while idle
//   reg_dump - flat register file, xN at [N*32+31:N*32]
//   tx       - UART serial line, idles high
//   busy     - frame in progress
//   done     - one-cycle pulse after the last stop bit
module reg_dump_uart_tx
    import dbg_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DUMP_W-1:0] reg_dump,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    logic [DUMP_W-1:0] snap_q;
    logic [7:0]        byte_idx_q;   // index of the byte currently on the line
    logic              busy_q;
    logic              done_q;

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              accept;
    logic              last_byte;
    logic [9:0]        snap_base;

    assign accept    = !busy_q && start && byte_ready;
    assign last_byte = (byte_idx_q == 8'(DUMP_BYTES));

    // The byte offered next is index byte_idx_q+1, i.e. data byte
    // byte_idx_q of the snapshot, at bit offset byte_idx_q*8. While idle
    // the offer is the header, taken on the same edge that accepts start.
    assign snap_base  = {byte_idx_q[6:0], 3'b000};
    assign byte_valid = busy_q ? !last_byte : start;
    assign byte_data  = busy_q ? snap_q[snap_base +: 8] : HEADER;

    assign busy = busy_q;
    assign done = done_q;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk  (clk),
        .rst  (rst),
        .valid(byte_valid),
        .data (byte_data),
        .tx   (tx),
        .ready(byte_ready)
    );

    // Snapshot is deliberately not reset; it is only read while busy.
    always_ff @(posedge clk) begin
        if (accept) begin
            snap_q <= reg_dump;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            byte_idx_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                busy_q     <= 1'b1;
                byte_idx_q <= '0;
            end else if (busy_q && byte_ready) begin
                // Serializer is in the last stop-bit cycle of the current byte.
                if (last_byte) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    byte_idx_q <= byte_idx_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: doc/reg_dump_uart_tx.md
# reg_dump_uart_tx

Debug transmitter that captures the pipeline's flat 32×32-bit register-file dump and serializes it over a UART 8N1 line. It sits beside the pipeline top level on the `reg_dump` bus: a start pulse snapshots all 32 registers, then the block sends one header byte and 128 data bytes. Its purpose is to let a host read processor state from FPGA hardware without a simulator.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (115200 baud at 100 MHz). Legal values are 2 and above.
- `HEADER`, default 8'hA5: sync byte sent before the dump.

Ports (clock and reset first):
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `start`  input  1  request to send a dump; sampled only in IDLE.
- `reg_dump`  input  1024  flat register file. Register xN occupies bits [N*32+31 : N*32], so x0 is [31:0].
- `tx`  output  1  UART serial line; idles high.
- `busy`  output  1  high from the cycle after an accepted start until the frame ends.
- `done`  output  1  one-cycle pulse when the last stop bit completes.

## Operation
Frame content:
- 129 bytes in total, each sent as 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1).
- No idle gap between bytes.
- Byte 0 is `HEADER`.
- Byte k for k = 1..128 is `snap[(r*32 + b*8) +: 8]`, where r = (k-1)/4 and b = (k-1)%4.
- Result: registers go out x0 to x31, each register little-endian.

Snapshot:
- The edge that accepts `start` copies `reg_dump` into a 1024-bit `snap` register.
- Later changes on `reg_dump` do not affect the frame in progress.

FSM states: IDLE, START, DATA, STOP.
- IDLE → START when `start`=1. On that edge: capture `snap`, set byte index to 0, clear the bit-cycle counter. `tx` stays 1 during IDLE.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: `tx` = current_byte[bit]. Each bit is held CLKS_PER_BIT cycles. After bit 7, go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. Then:
  - if byte index < 128: increment the index and go to START;
  - otherwise go to IDLE, pulse `done`, and drop `busy`.

Counters and widths:
- Bit-cycle counter is $clog2(CLKS_PER_BIT) bits and wraps to 0 at CLKS_PER_BIT-1.
- Bit index is 3 bits.
- Byte index is 8 bits and never exceeds 128.

Boundary conditions:
- `start` while busy is ignored, with no queuing.
- `start` asserted in the IDLE cycle that immediately follows `done` is accepted.
- `start` held high continuously produces back-to-back frames, each separated by exactly one IDLE cycle.
- `rst`=0 mid-frame: on the next edge, `tx`=1, `busy`=0, `done`=0, and the FSM returns to IDLE. The partial frame is abandoned.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, FSM=IDLE, all counters 0. `snap` is not reset.
- `start` sampled high at edge E: `busy` and the start bit (`tx`=0) both appear after E. A one-cycle latency is fixed.
- Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame duration is 1290 × CLKS_PER_BIT cycles, measured from the first start-bit cycle to the last stop-bit cycle inclusive.
- `done` is high during the cycle after the last stop-bit cycle; `busy` is 0 in that same cycle.
- `tx`, `busy` and `done` are driven directly from flops, with no combinational path from inputs.

## Structure
- Shared package `dbg_pkg`:
  - FSM state enum (IDLE/START/DATA/STOP);
  - `DUMP_BYTES` = 128;
  - `NUM_REGS` = 32.
- Sub-module `uart_tx_byte`:
  - handles START/DATA/STOP bit timing for one byte;
  - ports: `clk`, `rst`, `valid`, `data[7:0]`, `tx`, `ready`.
- The top FSM sequences byte indices and the header, and drives `busy`/`done`.
- The byte mux is combinational from `snap` and the byte index.

## Test plan
All scenarios use CLKS_PER_BIT=4.
1. **Reset:** hold `rst`=0 for 3 cycles → `tx`=1, `busy`=0, `done`=0. After release, with `start`=0 for 100 cycles, outputs are unchanged.
2. **Full frame:** xN = 32'h1000_0000+N, pulse `start` → UART decoder sees A5, 00 00 00 10, 01 00 00 10, …, 1F 00 00 10. `done` pulses at cycle 5161 after the start edge; `busy` is high for 5160 cycles.
3. **Snapshot:** change `reg_dump` to all-ones 10 cycles after `start` → the frame still carries the original values.
4. **Start while busy:** pulse `start` at byte 50 → no effect; exactly one `done` and 129 bytes.
5. **Reset mid-frame:** `rst`=0 during byte 20 → next cycle `tx`=1, `busy`=0. A new `start` then yields a complete, correct frame beginning with A5.
6. **Held start:** `start` held high → two consecutive frames with exactly 1 IDLE cycle between `done` and the next start bit.
